// File: rtl/pg_config_sequencer_if.sv
// Register-bus port of the pulse-generator config sequencer: arbiter handshake
// plus write strobe, address, write data and registered read data.
//
// Handshake: the sequencer raises o_bus_req and waits; the arbiter answers with
// i_bus_gnt and must hold it high until o_bus_req drops. A low grant after
// ownership began is treated as a loss and ends the sequence. o_wr qualifies
// o_addr/o_data for one cycle per write; i_rd_data returns the register at the
// address presented one cycle earlier.
interface pg_config_sequencer_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  o_bus_req;
  logic                  i_bus_gnt;
  logic                  o_wr;
  logic [ADDR_WIDTH-1:0] o_addr;
  logic [DATA_WIDTH-1:0] o_data;
  logic [DATA_WIDTH-1:0] i_rd_data;

  modport master (
    output o_bus_req, o_wr, o_addr, o_data,
    input  i_bus_gnt, i_rd_data
  );

  modport slave (
    input  o_bus_req, o_wr, o_addr, o_data,
    output i_bus_gnt, i_rd_data
  );
endinterface

// File: rtl/pg_config_sequencer.sv
// Loads a 14-byte pulse-generator channel configuration with pulse_ena cleared
// first and armed last, then reads every register back and verifies it.
module pg_config_sequencer #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [14*DATA_WIDTH-1:0] i_cfg,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_error,
  output logic [3:0]               o_err_offset,
  output logic [2:0]               o_dbg_state,
  pg_config_sequencer_if.master    bus
);
  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_DIS  = 3'd2,
    S_WR   = 3'd3,
    S_ARM  = 3'd4,
    S_RD   = 3'd5,
    S_CHK  = 3'd6
  } state_t;

  state_t                   r_state;
  logic [3:0]               r_idx;
  logic [14*DATA_WIDTH-1:0] r_shadow;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_error;
  logic [3:0]               r_err_offset;
  logic                     r_bus_req;
  logic                     r_wr;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]    r_data;

  logic                     w_gnt_lost;
  logic                     w_chk_en;
  logic                     w_mismatch;
  logic [3:0]               w_chk_off;
  logic [DATA_WIDTH-1:0]    w_exp;

  function automatic logic [DATA_WIDTH-1:0] f_byte(input logic [14*DATA_WIDTH-1:0] sh,
                                                   input logic [3:0] k);
    return sh[int'(k)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [3:0] k);
    return BASE_ADDR + ADDR_WIDTH'(k);
  endfunction

  // Read data lags the address by one cycle, so RD at index k checks offset k-1.
  always_comb begin
    w_gnt_lost = (r_state inside {S_DIS, S_WR, S_ARM, S_RD, S_CHK}) && !bus.i_bus_gnt;
    w_chk_off  = (r_state == S_CHK) ? LAST_IDX : (r_idx - 4'd1);
    w_chk_en   = !w_gnt_lost &&
                 (((r_state == S_RD) && (r_idx != 4'd0)) || (r_state == S_CHK));
    w_exp      = f_byte(r_shadow, w_chk_off);
    w_mismatch = w_chk_en && (bus.i_rd_data != w_exp);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_offset <= '0;
      r_bus_req    <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_gnt_lost) begin
        r_state      <= S_IDLE;
        r_idx        <= '0;
        r_busy       <= 1'b0;
        r_bus_req    <= 1'b0;
        r_wr         <= 1'b0;
        r_addr       <= '0;
        r_data       <= '0;
        r_error      <= 1'b1;
        r_err_offset <= 4'hF;
        r_done       <= 1'b1;
      end else begin
        if (w_mismatch) begin
          r_error <= 1'b1;
          if (!r_error) r_err_offset <= w_chk_off;
        end
        case (r_state)
          // A start coinciding with the done pulse is dropped on purpose.
          S_IDLE: if (i_start && !r_done) begin
            r_shadow     <= i_cfg;
            r_error      <= 1'b0;
            r_err_offset <= '0;
            r_busy       <= 1'b1;
            r_bus_req    <= 1'b1;
            r_state      <= S_REQ;
          end
          S_REQ: if (bus.i_bus_gnt) begin
            r_wr    <= 1'b1;
            r_addr  <= BASE_ADDR;
            r_data  <= '0;
            r_state <= S_DIS;
          end
          S_DIS: begin
            r_idx   <= 4'd1;
            r_addr  <= f_addr(4'd1);
            r_data  <= f_byte(r_shadow, 4'd1);
            r_state <= S_WR;
          end
          S_WR: begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_addr  <= BASE_ADDR;
              r_data  <= f_byte(r_shadow, 4'd0);
              r_state <= S_ARM;
            end else begin
              r_idx  <= r_idx + 4'd1;
              r_addr <= f_addr(r_idx + 4'd1);
              r_data <= f_byte(r_shadow, r_idx + 4'd1);
            end
          end
          S_ARM: begin
            r_wr    <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_addr  <= f_addr(4'd0);
            r_state <= S_RD;
          end
          S_RD: begin
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_addr  <= '0;
              r_state <= S_CHK;
            end else begin
              r_idx  <= r_idx + 4'd1;
              r_addr <= f_addr(r_idx + 4'd1);
            end
          end
          S_CHK: begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_bus_req <= 1'b0;
            r_addr    <= '0;
            r_done    <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_err_offset  = r_err_offset;
  assign o_dbg_state   = r_state;
  assign bus.o_bus_req = r_bus_req;
  assign bus.o_wr      = r_wr;
  assign bus.o_addr    = r_addr;
  assign bus.o_data    = r_data;
endmodule

// File: tb/tb_pg_config_sequencer.sv
// Scoreboard bench for pg_config_sequencer: bus events and completion results
// are queued at stimulus time and checked by an independent negedge monitor.
module tb_pg_config_sequencer;
  localparam int AW = 8;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic         clk     = 1'b0;
  logic         i_rst   = 1'b1;
  logic         i_start = 1'b0;
  logic         act_b   = 1'b0;
  logic         gnt     = 1'b1;
  logic [111:0] i_cfg   = '0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs (A: base 0x00, B: base 0xF8) ----------------
  pg_config_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  pg_config_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();

  logic       a_busy, a_done, a_error, b_busy, b_done, b_error;
  logic [3:0] a_err_off, b_err_off;
  logic [2:0] a_dbg, b_dbg;
  logic [7:0] rd_data;
  logic       start_a, start_b;

  assign start_a = i_start & ~act_b;
  assign start_b = i_start & act_b;

  pg_config_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(8'h00)) dut_a (
    .i_clk(clk), .i_rst(i_rst), .i_start(start_a), .i_cfg(i_cfg),
    .o_busy(a_busy), .o_done(a_done), .o_error(a_error), .o_err_offset(a_err_off),
    .o_dbg_state(a_dbg), .bus(bus_a)
  );

  pg_config_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(8'hF8)) dut_b (
    .i_clk(clk), .i_rst(i_rst), .i_start(start_b), .i_cfg(i_cfg),
    .o_busy(b_busy), .o_done(b_done), .o_error(b_error), .o_err_offset(b_err_off),
    .o_dbg_state(b_dbg), .bus(bus_b)
  );

  assign bus_a.i_bus_gnt = gnt;
  assign bus_b.i_bus_gnt = gnt;
  assign bus_a.i_rd_data = rd_data;
  assign bus_b.i_rd_data = rd_data;

  // Observed view of whichever DUT is under test.
  logic       m_wr, m_req, m_busy, m_done, m_error, m_rd;
  logic [7:0] m_addr, m_data;
  logic [3:0] m_err_off;
  logic [2:0] m_dbg;
  assign m_wr      = act_b ? bus_b.o_wr      : bus_a.o_wr;
  assign m_req     = act_b ? bus_b.o_bus_req : bus_a.o_bus_req;
  assign m_addr    = act_b ? bus_b.o_addr    : bus_a.o_addr;
  assign m_data    = act_b ? bus_b.o_data    : bus_a.o_data;
  assign m_busy    = act_b ? b_busy          : a_busy;
  assign m_done    = act_b ? b_done          : a_done;
  assign m_error   = act_b ? b_error         : a_error;
  assign m_err_off = act_b ? b_err_off       : a_err_off;
  assign m_dbg     = act_b ? b_dbg           : a_dbg;
  assign m_rd      = (m_dbg == 3'd5);

  // ---------------- register bank model ----------------
  logic [7:0] mem [256];
  logic       cor_en = 1'b0;
  logic [7:0] cor_a1 = 8'h00;
  logic [7:0] cor_a2 = 8'h00;

  always @(posedge clk) begin
    if (m_wr && gnt) mem[m_addr] <= m_data;
    if (cor_en && m_addr == cor_a1)      rd_data <= 8'hFF;
    else if (cor_en && m_addr == cor_a2) rd_data <= mem[m_addr] ^ 8'h5A;
    else                                 rd_data <= mem[m_addr];
  end

  // ---------------- scoreboard ----------------
  int tests    = 0;
  int fails    = 0;
  int t0       = 0;
  int done_cnt = 0;

  logic [16:0] exp_q[$];   // {is_write, addr, data}
  logic [14:0] done_q[$];  // {busy, bus_req, error, err_offset, cycle}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] got);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h with nothing expected at t=%0t", name, got, $time);
  endtask

  logic [16:0] got_ev;
  logic [14:0] got_d;

  always @(negedge clk) begin
    if (m_wr === 1'b1 || m_rd === 1'b1) begin
      got_ev = {m_wr, m_addr, (m_wr ? m_data : 8'h00)};
      if (exp_q.size() == 0) fail_now("bus_unexpected", 32'(got_ev));
      else check("bus_event", 32'(got_ev), 32'(exp_q.pop_front()));
    end
    if (m_done === 1'b1) begin
      done_cnt++;
      got_d = {m_busy, m_req, m_error, m_err_off, 8'(cyc - t0)};
      if (done_q.size() == 0) fail_now("done_unexpected", 32'(got_d));
      else check("done_result", 32'(got_d), 32'(done_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_seq(input logic [111:0] cfg, input logic [7:0] base, input int last_wr);
    logic [7:0] a;
    exp_q.push_back({1'b1, base, 8'h00});
    for (int k = 1; k <= last_wr; k++) begin
      a = base + 8'(k);
      exp_q.push_back({1'b1, a, cfg[8*k +: 8]});
    end
    if (last_wr == 13) begin
      exp_q.push_back({1'b1, base, cfg[7:0]});
      for (int k = 0; k < 14; k++) begin
        a = base + 8'(k);
        exp_q.push_back({1'b0, a, 8'h00});
      end
    end
  endtask

  task automatic push_done(input logic err, input logic [3:0] off, input logic [7:0] c);
    done_q.push_back({1'b0, 1'b0, err, off, c});
  endtask

  task automatic start_seq(input logic [111:0] cfg);
    @(negedge clk);
    i_cfg   = cfg;
    i_start = 1'b1;
    t0      = cyc;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < 100 && done_cnt == n0; i++) @(negedge clk);
    check({name, "_done_seen"}, 32'(done_cnt != n0), 32'd1);
    check({name, "_bus_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"},    32'(m_busy),    32'd0);
    check({name, "_done"},    32'(m_done),    32'd0);
    check({name, "_error"},   32'(m_error),   32'd0);
    check({name, "_err_off"}, 32'(m_err_off), 32'd0);
    check({name, "_bus_req"}, 32'(m_req),     32'd0);
    check({name, "_wr"},      32'(m_wr),      32'd0);
    check({name, "_addr"},    32'(m_addr),    32'd0);
    check({name, "_data"},    32'(m_data),    32'd0);
    check({name, "_state"},   32'(m_dbg),     32'd0);
  endtask

  // ---------------- stimulus ----------------
  logic [111:0] cfg_nom, cfg_alt, cfg_junk;
  int           n0;

  initial begin
    for (int k = 0; k < 14; k++) begin
      cfg_nom[8*k +: 8] = 8'h10 + 8'(k);
      cfg_alt[8*k +: 8] = 8'hA0 + 8'(3*k);
    end
    cfg_junk = {14{8'h55}};

    repeat (3) @(negedge clk);
    check_zero("reset");
    i_rst = 1'b0;

    // Nominal sequence: done in cycle 32, clean result.
    push_seq(cfg_nom, 8'h00, 13);
    push_done(1'b0, 4'h0, 8'd32);
    start_seq(cfg_nom);
    wait_done("nominal");
    check("nominal_mem_ena", 32'(mem[8'h00]), 32'h10);
    check("nominal_mem_13",  32'(mem[8'h0D]), 32'h1D);

    // Start while busy (cycle 10) and start during done (cycle 32) are both ignored.
    push_seq(cfg_alt, 8'h00, 13);
    push_done(1'b0, 4'h0, 8'd32);
    n0 = done_cnt;
    start_seq(cfg_alt);
    repeat (9) @(negedge clk);
    i_cfg = cfg_junk; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (21) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("start_on_done_busy", 32'(m_busy), 32'd0);
    check("start_on_done_req",  32'(m_req),  32'd0);
    repeat (5) @(negedge clk);
    check("busy_start_one_done", 32'(done_cnt - n0), 32'd1);
    check("busy_start_drained",  32'(exp_q.size()),  32'd0);

    // Grant delayed 5 cycles after request: no bus writes meanwhile, done in cycle 37.
    gnt = 1'b0;
    push_seq(cfg_nom, 8'h00, 13);
    push_done(1'b0, 4'h0, 8'd37);
    start_seq(cfg_nom);
    for (int i = 1; i <= 5; i++) begin
      check("gnt_wait_no_wr", 32'(m_wr),  32'd0);
      check("gnt_wait_req",   32'(m_req), 32'd1);
      @(negedge clk);
    end
    gnt = 1'b1;
    wait_done("gnt_delay");

    // Readback mismatch at offsets 6 and 9: first one is reported.
    cor_a1 = 8'h06; cor_a2 = 8'h09; cor_en = 1'b1;
    push_seq(cfg_nom, 8'h00, 13);
    push_done(1'b1, 4'h6, 8'd32);
    start_seq(cfg_nom);
    wait_done("mismatch");
    cor_en = 1'b0;

    // Grant drops while offset 4 is being written.
    push_seq(cfg_nom, 8'h00, 4);
    push_done(1'b1, 4'hF, 8'd7);
    n0 = done_cnt;
    start_seq(cfg_nom);
    for (int i = 0; i < 40 && !(m_wr === 1'b1 && m_addr == 8'h04); i++) @(negedge clk);
    check("drop_cycle", 32'(cyc - t0), 32'd6);
    gnt = 1'b0;
    @(negedge clk);
    check("drop_wr_off", 32'(m_wr), 32'd0);
    gnt = 1'b1;
    @(negedge clk);
    check("drop_one_done", 32'(done_cnt - n0), 32'd1);
    check("drop_drained",  32'(exp_q.size()),  32'd0);
    check("drop_mem_ena",  32'(mem[8'h00]),    32'h00);

    // Reset in cycle 20 of a sequence: everything clears, no done, restart works.
    push_seq(cfg_alt, 8'h00, 13);
    push_done(1'b0, 4'h0, 8'd32);
    n0 = done_cnt;
    start_seq(cfg_alt);
    repeat (19) @(negedge clk);
    i_rst = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    exp_q.delete();
    done_q.delete();
    i_rst = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset_no_done", 32'(done_cnt - n0), 32'd0);
    push_seq(cfg_nom, 8'h00, 13);
    push_done(1'b0, 4'h0, 8'd32);
    start_seq(cfg_nom);
    wait_done("after_reset");

    // Address wrap with base 0xF8: offsets 8..13 land on 0x00..0x05.
    act_b = 1'b1;
    @(negedge clk);
    push_seq(cfg_nom, 8'hF8, 13);
    push_done(1'b0, 4'h0, 8'd32);
    start_seq(cfg_nom);
    wait_done("wrap");
    check("wrap_mem_F8", 32'(mem[8'hF8]), 32'h10);
    check("wrap_mem_00", 32'(mem[8'h00]), 32'h18);
    check("wrap_mem_05", 32'(mem[8'h05]), 32'h1D);

    repeat (3) @(negedge clk);
    check("final_done_q_empty", 32'(done_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at t=%0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pg_config_sequencer.md
# pg_config_sequencer

Loads one complete pulse-generator channel configuration (14 byte registers) over the shared 8-bit register bus, then reads every register back and verifies it. The pulse-enable register is cleared first and written with its final value last, so the channel never runs on a partially updated configuration. The block sits between the shared register bus and whatever issues channel updates, such as a GPS-time scheduler or host command decoder. It acquires the bus through a request/grant handshake with the bus arbiter.

## Interface
Parameters:
- ADDR_WIDTH, 8, register bus address width
- DATA_WIDTH, 8, register bus data width; fixed at 8
- BASE_ADDR, 8'h00, address of the channel's pulse-enable register; offsets 0..13 map to BASE_ADDR+0..13

Offset order: 0 pulse_ena, 1 year_h, 2 year_l, 3 month, 4 day, 5 hour, 6 minutes, 7 seconds, 8-10 width_high_2..0, 11-13 width_period_2..0.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  start request, single-cycle pulse; ignored while o_busy=1
- i_cfg  in  112  configuration; byte k at [8k+7:8k] is offset k; sampled only on an accepted i_start
- o_busy  out  1  sequence in progress
- o_done  out  1  one-cycle completion pulse
- o_error  out  1  result of last sequence: readback mismatch or grant loss; valid from o_done until the next accepted start
- o_err_offset  out  4  first mismatching offset; 4'hF on grant loss
- o_bus_req  out  1  bus request to arbiter
- i_bus_gnt  in  1  bus grant from arbiter
- o_wr  out  1  register write strobe
- o_addr  out  ADDR_WIDTH  register address
- o_data  out  8  write data
- i_rd_data  in  8  register read data; valid one cycle after the read address is presented

## Operation
- Reset values: all outputs 0, state IDLE, index 0, shadow cleared.
- IDLE: on i_start, copy i_cfg into the 112-bit shadow register, clear o_error and o_err_offset, set o_busy, and go to REQ.
- REQ: assert o_bus_req. When i_bus_gnt=1, go to DIS.
- DIS: one cycle with o_wr=1, o_addr=BASE_ADDR, o_data=8'h00. Set index=1 and go to WR.
- WR: o_wr=1, o_addr=BASE_ADDR+index, o_data=shadow[index]. Increment index. After index 13, go to ARM.
- ARM: one cycle with o_wr=1, o_addr=BASE_ADDR, o_data=shadow[0]. Set index=0 and go to RD.
- RD: o_wr=0, o_addr=BASE_ADDR+index, for index 0..13, one read per cycle.
  - When index is k≥1, compare i_rd_data against shadow[k-1].
  - After index 13, go to CHK.
- CHK: o_wr=0, o_addr=0. Compare i_rd_data against shadow[13], then go to IDLE.
- Mismatch: set o_error=1. Latch o_err_offset only on the first mismatch; later mismatches do not overwrite it. Checking continues to the end.
- Grant loss: if i_bus_gnt=0 in any state from DIS through CHK, abort immediately:
  - go to IDLE with o_error=1 and o_err_offset=4'hF;
  - pulse o_done;
  - stop bus writes in the same cycle the loss is sampled; the bus outputs go to 0 on the next cycle.
- Bus outputs: o_wr, o_addr and o_data are 0 in IDLE and REQ.
- o_bus_req: 1 from REQ through CHK; 0 in IDLE.
- Address arithmetic: BASE_ADDR+index wraps modulo 2^ADDR_WIDTH.
- Reset mid-sequence: return to IDLE, drop o_bus_req, and do not pulse o_done.

## Timing
- All outputs are registered.
- i_start is sampled at edge 0. REQ is cycle 1; with grant already high, DIS is cycle 2.
- Cycle map: WR cycles 3-15, ARM cycle 16, RD cycles 17-30, CHK cycle 31. In cycle 32, o_done=1, o_busy=0 and o_bus_req=0.
- Each extra cycle of grant delay shifts the whole map by one.
- Bus totals per sequence: 15 writes (offset 0 written twice) and 14 reads.
- o_error and o_err_offset are stable when o_done is high.
- i_start in the same cycle as o_done is ignored. A new start is accepted from the following cycle.

## Test plan
- Nominal: i_cfg bytes = 0x10+k, grant tied high, a 14-byte register-bank model attached.
  - Bus trace: (BASE,00), (BASE+1,11) … (BASE+13,1D), (BASE,10), then 14 reads.
  - o_done in cycle 32 with o_error=0.
- Grant delay: grant rises 5 cycles after o_bus_req. No bus activity before the grant; o_done arrives in cycle 37.
- Readback mismatch: the model corrupts offset 6 (returns 0xFF) and offset 9. Result o_error=1, o_err_offset=6.
- Grant drop: deassert i_bus_gnt during WR at offset 4.
  - o_wr=0 on the next cycle, o_done pulses, o_error=1, o_err_offset=F.
  - Offset 0 holds 00 in the model.
- Busy start and reset:
  - A second i_start at cycle 10 does not change the trace.
  - i_rst at cycle 20: all outputs 0 on the next cycle, no o_done, and a new start runs the full sequence.
- Address wrap: BASE_ADDR=8'hF8. Offsets 8..13 go to 0x00..0x05 and the sequence completes with o_error=0.
